// File: rtl/fpu_issue_buffer.sv
// Operand issue FIFO and registered result capture around the combinational FPU_32bit add/sub core.
// Optional macro FPU_ISSUE_BYPASS_EN lets a push into an idle buffer skip the FIFO straight into the operand stage.
module fpu_issue_buffer #(
  parameter int SIZE_DATA = 32,
  parameter int NUM_OP    = 2,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [NUM_OP-1:0]          i_alu_op,
  input  logic [SIZE_DATA-1:0]       i_data_a,
  input  logic [SIZE_DATA-1:0]       i_data_b,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_fpu_alu_op,
  output logic [SIZE_DATA-1:0]       o_fpu_data_a,
  output logic [SIZE_DATA-1:0]       o_fpu_data_b,
  input  logic [SIZE_DATA-1:0]       i_fpu_result,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SIZE_DATA-1:0]       o_result,
  output logic [TAG_W-1:0]           o_tag,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + 2 * SIZE_DATA + TAG_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] entry_in;

  logic             vld_p0;
  logic [TAG_W-1:0] tag_p0;

  logic push;
  logic adv_res;
  logic stage_free;
  logic load_op;
  logic bypass;
  logic fifo_wr;

  // Only bit 0 of the op code selects add/sub; the rest is deliberately dropped.
  wire unused_alu_op = &{1'b0, i_alu_op};

  assign entry_in   = {i_alu_op[0], i_data_a, i_data_b, i_tag};
  assign o_ready    = !i_rst && (count < CNT_W'(DEPTH));
  assign push       = i_valid && o_ready;
  assign adv_res    = vld_p0 && (!o_valid || i_ready);
  assign stage_free = !vld_p0 || adv_res;
  assign load_op    = (count != '0) && stage_free;

`ifdef FPU_ISSUE_BYPASS_EN
  assign bypass = push && (count == '0) && stage_free;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = push && !bypass;
  assign o_count = count;

  // FIFO storage and control
  always_ff @(posedge i_clk) begin
    if (fifo_wr) begin
      mem[wptr] <= entry_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (fifo_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (load_op) begin
        rptr <= rptr + 1'b1;
      end
      case ({fifo_wr, load_op})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Operand stage (p0): drives the FPU, holds its value while idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0 <= 1'b0;
    end else if (load_op || bypass) begin
      vld_p0 <= 1'b1;
    end else if (adv_res) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fpu_alu_op <= 1'b0;
      o_fpu_data_a <= '0;
      o_fpu_data_b <= '0;
      tag_p0       <= '0;
    end else if (load_op) begin
      {o_fpu_alu_op, o_fpu_data_a, o_fpu_data_b, tag_p0} <= mem[rptr];
    end else if (bypass) begin
      {o_fpu_alu_op, o_fpu_data_a, o_fpu_data_b, tag_p0} <= entry_in;
    end
  end

  // Result stage (p1): captures the combinational FPU output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
    end else if (adv_res) begin
      o_valid  <= 1'b1;
      o_result <= i_fpu_result;
      o_tag    <= tag_p0;
    end else if (o_valid && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Directed and randomized bench for fpu_issue_buffer with a small integer-valued float add/sub stand-in for FPU_32bit.
module tb_fpu_issue_buffer;

`ifdef FPU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
  localparam int SS_COUNT = 0;
`else
  localparam int LAT = 2;
  localparam int SS_COUNT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_alu_op;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic [3:0]  i_tag;
  logic        o_fpu_alu_op;
  logic [31:0] o_fpu_data_a;
  logic [31:0] o_fpu_data_b;
  logic [31:0] fpu_result;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [3:0]  o_tag;
  logic [2:0]  o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_alu_op     (i_alu_op),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .i_tag        (i_tag),
    .o_fpu_alu_op (o_fpu_alu_op),
    .o_fpu_data_a (o_fpu_data_a),
    .o_fpu_data_b (o_fpu_data_b),
    .i_fpu_result (fpu_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_tag        (o_tag),
    .o_count      (o_count)
  );

  // Exact for the small integer magnitudes used here
  function automatic logic [31:0] int2fp(input int v);
    int mag;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    int e;
    int mag;
    if (f[30:0] == 31'h0) return 0;
    e   = int'(f[30:23]) - 127;
    mag = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fpu_stub(input logic op, input logic [31:0] a, input logic [31:0] b);
    return int2fp(op ? fp2int(a) - fp2int(b) : fp2int(a) + fp2int(b));
  endfunction

  assign fpu_result = fpu_stub(o_fpu_alu_op, o_fpu_data_a, o_fpu_data_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_alu_op = 2'b00; i_data_a = '0; i_data_b = '0; i_tag = '0;
    tick; tick;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b count=%0d ready=%b, want 0 0 0", o_valid, o_count, o_ready);
    end
    checks++;
    if (o_result !== 32'h0 || o_tag !== 4'h0 || o_fpu_data_a !== 32'h0 || o_fpu_data_b !== 32'h0 || o_fpu_alu_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: result=%h tag=%h a=%h b=%h op=%b, want zeros", o_result, o_tag, o_fpu_data_a, o_fpu_data_b, o_fpu_alu_op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", o_ready);
    end
    tick;
  endtask

  task automatic test_single(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] tag, input logic [31:0] exp_res);
    int n;
    i_ready = 1'b1;
    i_valid = 1'b1; i_alu_op = {1'b1, op}; i_data_a = a; i_data_b = b; i_tag = tag;
    tick;
    i_valid = 1'b0; i_alu_op = 2'b00;
    n = 0;
    while (!o_valid && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, n, LAT);
    end
    checks++;
    if (o_result !== exp_res || o_tag !== tag) begin
      errors++;
      $display("FAIL %s_result: result=%h tag=%0d want %h %0d", name, o_result, o_tag, exp_res, tag);
    end
    tick;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: o_valid=%b want 0", name, o_valid);
    end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_alu_op = 2'b00; i_tag = 4'(i);
      i_data_a = int2fp(i + 1); i_data_b = 32'h3F80_0000;
      if (o_ready) accepted++;
      tick;
    end
    i_valid = 1'b0;
    checks++;
    if (accepted !== 6) begin
      errors++;
      $display("FAIL bp_accepted: got %0d want 6", accepted);
    end
    checks++;
    if (o_ready !== 1'b0 || o_count !== 3'd4 || o_valid !== 1'b1 || o_tag !== 4'd0) begin
      errors++;
      $display("FAIL bp_full: ready=%b count=%0d valid=%b tag=%0d want 0 4 1 0", o_ready, o_count, o_valid, o_tag);
    end
    tick;
    checks++;
    if (o_valid !== 1'b1 || o_tag !== 4'd0 || o_result !== 32'h4000_0000) begin
      errors++;
      $display("FAIL bp_hold: valid=%b tag=%0d result=%h want 1 0 40000000", o_valid, o_tag, o_result);
    end
    i_ready = 1'b1;
    for (int e = 0; e < 6; e++) begin
      checks++;
      if (o_valid !== 1'b1 || o_tag !== 4'(e) || o_result !== int2fp(e + 2)) begin
        errors++;
        $display("FAIL bp_drain_%0d: valid=%b tag=%0d result=%h want 1 %0d %h", e, o_valid, o_tag, o_result, e, int2fp(e + 2));
      end
      tick;
    end
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b count=%0d want 0 0", o_valid, o_count);
    end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    i_ready = 1'b1;
    while (got < 20 && cyc < 40) begin
      if (cyc < 20) begin
        i_valid = 1'b1; i_alu_op = {1'b0, cyc[0]}; i_tag = 4'(cyc);
        i_data_a = int2fp(cyc + 1); i_data_b = int2fp(cyc);
        checks++;
        if (o_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_%0d: got %b want 1", cyc, o_ready);
        end
      end else begin
        i_valid = 1'b0;
      end
      tick;
      if (cyc < 20) begin
        checks++;
        if (o_count !== 3'(SS_COUNT)) begin
          errors++;
          $display("FAIL b2b_count_%0d: got %0d want %0d", cyc, o_count, SS_COUNT);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_tag !== 4'(got) || o_result !== int2fp(got[0] ? 1 : 2 * got + 1)) begin
          errors++;
          $display("FAIL b2b_out_%0d: tag=%0d result=%h want %0d %h", got, o_tag, o_result, got[3:0], int2fp(got[0] ? 1 : 2 * got + 1));
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      cyc++;
    end
    i_valid = 1'b0;
    checks++;
    if (got !== 20 || (last - first) !== 19) begin
      errors++;
      $display("FAIL b2b_stream: got %0d results over span %0d, want 20 over 19", got, last - first);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_alu_op = 2'b00; i_tag = 4'(i + 8);
      i_data_a = int2fp(i + 1); i_data_b = int2fp(1);
      tick;
    end
    i_valid = 1'b0;
    checks++;
    if (o_count !== 3'd3 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: count=%0d valid=%b want 3 1", o_count, o_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%b count=%0d ready=%b want 0 0 1", o_valid, o_count, o_ready);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale_%0d: o_valid=%b tag=%0d want 0", i, o_valid, o_tag);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_res_q[$];
    logic [3:0]  exp_tag_q[$];
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int a;
    int b;
    logic op;
    while (recv < 100 && cyc < 3000) begin
      i_ready = 1'($urandom % 2);
      if (sent < 100) begin
        a = int'($urandom_range(1, 1000));
        b = int'($urandom_range(1, 1000));
        op = 1'($urandom % 2);
        i_valid = ($urandom % 4) != 0;
        i_alu_op = {1'($urandom % 2), op};
        i_data_a = int2fp(a); i_data_b = int2fp(b); i_tag = 4'(sent);
      end else begin
        i_valid = 1'b0;
      end
      if (i_valid && o_ready) begin
        exp_res_q.push_back(int2fp(op ? a - b : a + b));
        exp_tag_q.push_back(4'(sent));
        sent++;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected: tag=%0d result=%h with nothing outstanding", o_tag, o_result);
        end else begin
          if (o_tag !== exp_tag_q[0] || o_result !== exp_res_q[0]) begin
            errors++;
            $display("FAIL rnd_out_%0d: tag=%0d result=%h want %0d %h", recv, o_tag, o_result, exp_tag_q[0], exp_res_q[0]);
          end
          void'(exp_res_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
        recv++;
      end
      tick;
      cyc++;
    end
    i_valid = 1'b0;
    checks++;
    if (recv !== 100 || sent !== 100) begin
      errors++;
      $display("FAIL rnd_complete: sent=%0d received=%0d want 100 100", sent, recv);
    end
  endtask

  initial begin
    test_reset;
    test_single("add", 1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h4040_0000);
    test_single("sub", 1'b1, 32'h4040_0000, 32'h3F80_0000, 4'd2, 32'h4000_0000);
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_buffer.md
Name: fpu_issue_buffer

Overview:
- Operand issue and result capture stage wrapped around the combinational FPU_32bit add/sub core.
- Accepts tagged operations over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Registers the head operation into an operand stage that drives the FPU, then captures the FPU result into a registered output stage with its own valid/ready handshake.
- Replaces the ad-hoc input flops currently placed in front of FPU_32bit and adds backpressure.

Parameters:
- SIZE_DATA, 32: operand and result width.
- NUM_OP, 2: i_alu_op width. Only bit 0 is used.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- TAG_W, 4: width of the user tag carried alongside each operation.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  upstream may push. Equals !i_rst && (count < DEPTH).
- i_alu_op  in  NUM_OP  bit0: 0 = add, 1 = sub. Bit 1 is ignored and not stored.
- i_data_a  in  SIZE_DATA  operand A.
- i_data_b  in  SIZE_DATA  operand B.
- i_tag  in  TAG_W  user tag.
- o_fpu_alu_op  out  1  to FPU_32bit i_alu_op.
- o_fpu_data_a  out  SIZE_DATA  to FPU_32bit i_data_a.
- o_fpu_data_b  out  SIZE_DATA  to FPU_32bit i_data_b.
- i_fpu_result  in  SIZE_DATA  from FPU_32bit o_result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  SIZE_DATA  registered FPU result.
- o_tag  out  TAG_W  tag of o_result.
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy. Excludes the two pipeline stages.

Behaviour:
- Reset (i_rst = 1 at a rising edge):
  - count, read pointer, write pointer, op_vld and o_valid all go to 0.
  - o_fpu_*, o_result and o_tag go to 0.
  - Every in-flight operation is discarded; nothing is emitted afterwards.
  - o_ready is 0 while i_rst is high.
- Push = i_valid && o_ready. The entry is written at wptr and wptr increments modulo DEPTH.
- Result stage:
  - adv_res = op_vld && (!o_valid || i_ready).
  - On adv_res: o_result <= i_fpu_result, o_tag <= op_tag, o_valid <= 1.
  - Else, if o_valid && i_ready: o_valid <= 0.
- Operand stage:
  - load_op = (count > 0) && (!op_vld || adv_res).
  - On load_op: the FIFO head goes to o_fpu_* and op_tag, op_vld <= 1, and rptr increments modulo DEPTH.
  - Else, if adv_res: op_vld <= 0.
  - o_fpu_* hold their last value when op_vld = 0.
- Count update:
  - push only: +1.
  - pop (load_op) only: -1.
  - push and pop in the same cycle: count unchanged; both pointers advance.
- Full: o_ready = 0 and i_valid is ignored. Empty: no pop.
- Push into an empty FIFO is not visible to load_op until the next cycle.
- Latency, unloaded, i_ready = 1: push at edge k, operand stage at edge k+1, o_valid at edge k+2.
- Throughput: one operation per cycle with i_ready held high.
- Ordering: strictly FIFO, so tags emerge in push order.
- Capacity with i_ready = 0: DEPTH + 2 operations are accepted before o_ready drops.
- o_result, o_tag and o_valid are stable while o_valid && !i_ready.
- The block does no arithmetic. The FPU path is purely combinational between o_fpu_* and i_fpu_result.

Optional Feature:
- Macro: FPU_ISSUE_BYPASS_EN.
- When defined: if count == 0 and (!op_vld || adv_res), a push loads directly into the operand stage at that edge, bypassing the FIFO (count unchanged). Unloaded latency becomes 1 edge from push to o_valid.
- When undefined: every operation passes through the FIFO as above, with 2-edge latency.
- Ordering and capacity rules hold in both builds.

Test Plan:
- Single op, add: A = 3F800000, B = 40000000, op = 0, tag = 1. Expect o_valid after 2 edges, o_result = 40400000, o_tag = 1. With the bypass macro, expect 1 edge.
- Single op, sub: A = 40400000, B = 3F800000, op = 1. Expect o_result = 40000000.
- Backpressure: i_ready = 0, push tags 0..7 continuously. Expect 6 accepted, o_ready = 0 after the 6th, o_count = 4. Then i_ready = 1: expect tags 0..5 in order, one per cycle.
- Simultaneous push/pop at steady state, i_ready = 1, 20 back-to-back ops with incrementing tags. Expect o_count constant, pointers wrapping, tags 0..19 in order with no gaps.
- Reset mid-stream: with 3 ops queued and o_valid = 1, assert i_rst for 1 cycle. Expect o_valid = 0, o_count = 0, o_ready = 1 the cycle after deassert, and no stale results emitted.
- Random i_ready (50%) with 100 random ops. Expect every result equal to the FPU model of its tagged operands, in push order.
